// File: rtl/uart_rx_basic.sv
// uart_rx_basic: 8N1 serial receiver with glitch rejection, framing-error detection and break handling.
module uart_rx_basic #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state, state_d;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] clk_counter, cnt_d;
    logic [2:0]    bit_index, idx_d;
    logic [7:0]    shift_reg, shift_d, data_d;
    logic          valid_d, err_d;

    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            state       <= IDLE;
            clk_counter <= '0;
            bit_index   <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_sync     <= rx_meta;
            state       <= state_d;
            clk_counter <= cnt_d;
            bit_index   <= idx_d;
            shift_reg   <= shift_d;
            data_out    <= data_d;
            valid       <= valid_d;
            frame_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = clk_counter + 1'b1;
        idx_d   = bit_index;
        shift_d = shift_reg;
        data_d  = data_out;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                cnt_d   = '0;
                state_d = rx_sync ? IDLE : START;
            end
            START: if (clk_counter == HALF_LAST) begin
                state_d = rx_sync ? IDLE : DATA;
                idx_d   = '0;
            end
            DATA: if (clk_counter == BIT_LAST) begin
                cnt_d   = '0;
                shift_d = {rx_sync, shift_reg[7:1]};
                state_d = (bit_index == 3'd7) ? STOP : DATA;
                idx_d   = bit_index + 3'd1;
            end
            STOP: if (clk_counter == BIT_LAST) begin
                state_d = rx_sync ? IDLE : BRK;
                data_d  = rx_sync ? shift_reg : data_out;
                valid_d = rx_sync;
                err_d   = !rx_sync;
            end
            BRK: begin
                cnt_d   = '0;
                state_d = rx_sync ? IDLE : BRK;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state) cnt_d = '0;
    end
endmodule

// File: tb/tb_uart_rx_basic.sv
// tb_uart_rx_basic: directed frames for uart_rx_basic with a queue-based scoreboard checking every output pulse.
module tb_uart_rx_basic;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       valid, frame_err, busy;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_basic #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data_out(data_out), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; the next rising edge is edge 0 of the frame.
    task automatic frame(input logic [7:0] d, input logic stop, input bit chk_busy);
        int         e0;
        logic [9:0] f;
        e0 = cyc + 1;
        f  = {stop, d, 1'b0};
        exp_q.push_back('{err: !stop, data: stop ? d : last_good, cyc: e0 + 97});
        if (stop) last_good = d;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (10) begin
                if (chk_busy) chk("busy_window", busy, int'(cyc >= e0 + 2 && cyc <= e0 + 96));
                @(negedge clk);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (valid || frame_err)) begin
            checks++;
            if (valid && frame_err) begin
                errors++;
                $display("FAIL exclusive: valid and frame_err both high at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b data_out=%0h at cycle %0d, none expected",
                         valid, frame_err, data_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (frame_err != e.err || data_out != e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse: got err=%0b data=%0h cycle=%0d expected err=%0b data=%0h cycle=%0d",
                             frame_err, data_out, cyc, e.err, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        int e0;
        repeat (3) @(negedge clk);
        chk("reset_data", data_out, 8'h00);
        chk("reset_valid", valid, 0);
        chk("reset_err", frame_err, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame(8'hA5, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("a5_data_held", data_out, 8'hA5);

        e0 = cyc + 1;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        while (cyc < e0 + 6) @(negedge clk);
        chk("glitch_busy_before", busy, 1);
        @(negedge clk);
        chk("glitch_busy_after", busy, 0);
        chk("glitch_data", data_out, 8'hA5);
        repeat (10) @(negedge clk);

        frame(8'h3C, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        chk("break_busy", busy, 1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("break_exit_busy", busy, 0);
        chk("break_data", data_out, 8'hA5);
        frame(8'h0F, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("0f_data", data_out, 8'h0F);

        frame(8'h00, 1'b1, 1'b0);
        frame(8'hFF, 1'b1, 1'b0);
        frame(8'h55, 1'b1, 1'b0);
        frame(8'hAA, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("b2b_last", data_out, 8'hAA);

        begin
            logic [9:0] f;
            f = {1'b1, 8'hC3, 1'b0};
            for (int i = 0; i < 5; i++) begin
                rx = f[i];
                repeat (10) @(negedge clk);
            end
            rx = f[5];
            repeat (5) @(negedge clk);
        end
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        chk("midrst_data", data_out, 8'h00);
        chk("midrst_valid", valid, 0);
        chk("midrst_err", frame_err, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        repeat (20) @(negedge clk);
        chk("post_reset_idle", busy, 0);
        frame(8'h81, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("81_data", data_out, 8'h81);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
